sync_evt_rx: RTL

- Multi-channel receive side for toggle-encoded events crossing into the local `clk` domain.
- Each channel's `tog_in` bit is a level that the remote domain flips once per event.
- The block synchronises each bit through a parametrised flop chain and edge-detects it into a one-cycle pulse.
- It queues events per channel in saturating counters and delivers them one at a time on a round-robin valid/ready stream, with sticky per-channel overflow flags.

---
 rtl/sync_evt_rx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sync_evt_rx.sv
// Multi-channel toggle-event receiver: synchronise, edge-detect, count, round-robin stream out.
// Optional SYNC_EVT_RX_ACK_EN adds a per-channel ack_tog output flipped on each accept.
module sync_evt_rx #(
  parameter  int NCH         = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 4,
  localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  tog_in,
  output logic [NCH-1:0]  ev_pulse,
  output logic            ev_valid,
  output logic [CH_W-1:0] ev_chan,
  input  logic            ev_ready,
  output logic [NCH-1:0]  ovf,
  input  logic [NCH-1:0]  ovf_clr
`ifdef SYNC_EVT_RX_ACK_EN
  ,
  output logic [NCH-1:0]  ack_tog
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   s_last_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   nz;
  logic [NCH-1:0]   dec;
  logic             ev_valid_q, ev_valid_d;
  logic [CH_W-1:0]  ev_chan_q, ev_chan_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             load;
  logic             found;
  logic [CH_W-1:0]  sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      s_last_q <= '0;
    end else begin
      sync_q[0] <= tog_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      s_last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev_pulse = sync_q[SYNC_STAGES-1] ^ s_last_q;

  // Round-robin search from ptr; scanning offsets high-to-low leaves the nearest hit in sel.
  always_comb begin
    int idx;
    load  = !ev_valid_q || ev_ready;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (nz[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_chan_d  = ev_chan_q;
    ptr_d      = ptr_q;
    if (load) begin
      ev_valid_d = found;
      if (found) begin
        ev_chan_d = sel;
        ptr_d     = (int'(sel) == NCH - 1) ? '0 : sel + CH_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic inc;
      logic sat;
      assign nz[gi]  = |cnt_q[gi];
      assign dec[gi] = load && found && (sel == CH_W'(gi));
      assign inc     = ev_pulse[gi];
      assign sat     = inc && !dec[gi] && (cnt_q[gi] == CNT_MAX);

      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (inc && !dec[gi] && !sat) cnt_d[gi] = cnt_q[gi] + 1'b1;
        else if (dec[gi] && !inc)    cnt_d[gi] = cnt_q[gi] - 1'b1;
      end

      // A lost event in the same cycle as a clear keeps the flag set.
      assign ovf_d[gi] = sat || (ovf_q[gi] && !ovf_clr[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q[gi] <= '0;
        else     cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
      ptr_q      <= '0;
    end else begin
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_chan_q  <= ev_chan_d;
      ptr_q      <= ptr_d;
    end
  end

  assign ovf      = ovf_q;
  assign ev_valid = ev_valid_q;
  assign ev_chan  = ev_chan_q;

`ifdef SYNC_EVT_RX_ACK_EN
  logic [NCH-1:0] ack_tog_q, ack_tog_d;

  for (gi = 0; gi < NCH; gi++) begin : g_ack
    assign ack_tog_d[gi] = ack_tog_q[gi] ^ (ev_valid_q && ev_ready && (ev_chan_q == CH_W'(gi)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_tog_q <= '0;
    else     ack_tog_q <= ack_tog_d;
  end

  assign ack_tog = ack_tog_q;
`endif

endmodule
